// File: rtl/gray2binary_thresh_ctrl.sv
// gray2binary_thresh_ctrl
// Adaptive threshold controller for the gray-to-binary stage. It measures the
// mean luminance of each frame and presents it as the binariser threshold for
// the next frame. The threshold is only rewritten between frames.
// Optional feature: define THRESH_IIR_EN to average each new clamped mean
// with the previous threshold, which gives first-order smoothing across frames.
`timescale 1ns/1ps
module gray2binary_thresh_ctrl #(
  parameter logic [9:0] INIT_TH = 10'd500,
  parameter logic [9:0] MIN_TH  = 10'd64,
  parameter logic [9:0] MAX_TH  = 10'd960,
  parameter int         CNT_W   = 22
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iFVAL,
  input  logic       iDVAL,
  input  logic [9:0] iDATA,
  input  logic       iMANUAL,
  input  logic [9:0] iMAN_TH,
  output logic [9:0] oTHRESH,
  output logic       oTH_UPD,
  output logic       oBUSY
);

  localparam int SUM_W = CNT_W + 10;
  localparam int DCW   = $clog2(SUM_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [DCW-1:0]   DIV_LAST = DCW'(SUM_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DIVIDE = 2'd2,
    S_UPDATE = 2'd3
  } state_e;

  state_e           state_q;
  logic             fval_q;
  // Holds the pixel sum while accumulating; during the divide it is the
  // dividend shifting out MSB-first with quotient bits shifting in at the LSB.
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] rem_q;
  logic [DCW-1:0]   div_cnt_q;
  logic [9:0]       thresh_q;
  logic             upd_q;
  logic             busy_q;

  logic             fval_rise_d;
  logic             fval_fall_d;
  logic [CNT_W:0]   rem_shift_d;
  logic             div_ge_d;
  logic [CNT_W-1:0] rem_d;
  logic [9:0]       quot_d;
  logic [9:0]       clamp_d;
  logic [9:0]       th_new_d;

  // Frame edge detection, one restoring-divide step, and threshold calculation.
  always_comb begin
    fval_rise_d = iFVAL & ~fval_q;
    fval_fall_d = ~iFVAL & fval_q;

    rem_shift_d = {rem_q, sum_q[SUM_W-1]};
    div_ge_d    = (rem_shift_d >= {1'b0, count_q});
    if (div_ge_d) begin
      rem_d = CNT_W'(rem_shift_d - {1'b0, count_q});
    end else begin
      rem_d = rem_shift_d[CNT_W-1:0];
    end

    if (|sum_q[SUM_W-1:10]) begin
      quot_d = 10'h3FF;
    end else begin
      quot_d = sum_q[9:0];
    end

    if (quot_d < MIN_TH) begin
      clamp_d = MIN_TH;
    end else if (quot_d > MAX_TH) begin
      clamp_d = MAX_TH;
    end else begin
      clamp_d = quot_d;
    end

`ifdef THRESH_IIR_EN
    th_new_d = 10'(({1'b0, thresh_q} + {1'b0, clamp_d} + 11'd1) >> 1);
`else
    th_new_d = clamp_d;
`endif
  end

  // Measurement FSM with registered threshold, update pulse and busy flag.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= S_IDLE;
      fval_q    <= 1'b0;
      sum_q     <= '0;
      count_q   <= '0;
      rem_q     <= '0;
      div_cnt_q <= '0;
      thresh_q  <= INIT_TH;
      upd_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      fval_q <= iFVAL;
      upd_q  <= 1'b0;
      // A manual override follows iMAN_TH every cycle; measurement keeps running.
      if (iMANUAL) begin
        thresh_q <= iMAN_TH;
      end
      case (state_q)
        S_IDLE: begin
          if (fval_rise_d) begin
            // The pixel on the rising-edge cycle belongs to the frame.
            sum_q   <= iDVAL ? SUM_W'(iDATA) : '0;
            count_q <= iDVAL ? CNT_W'(1) : '0;
            state_q <= S_ACCUM;
            busy_q  <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (fval_fall_d) begin
            if (count_q == '0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              rem_q     <= '0;
              div_cnt_q <= '0;
              state_q   <= S_DIVIDE;
            end
          end else if (iFVAL && iDVAL && (count_q != CNT_MAX)) begin
            // Sum freezes together with a saturated count so the mean stays sane.
            sum_q   <= sum_q + SUM_W'(iDATA);
            count_q <= count_q + CNT_W'(1);
          end
        end
        S_DIVIDE: begin
          sum_q     <= {sum_q[SUM_W-2:0], div_ge_d};
          rem_q     <= rem_d;
          div_cnt_q <= div_cnt_q + DCW'(1);
          if (div_cnt_q == DIV_LAST) begin
            state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (!iMANUAL) begin
            thresh_q <= th_new_d;
            upd_q    <= 1'b1;
          end
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oTHRESH = thresh_q;
  assign oTH_UPD = upd_q;
  assign oBUSY   = busy_q;

endmodule
